// File: rtl/add_arbiter.sv
// ============================================================================
// add_arbiter: round-robin arbiter sharing one add/sub unit between two
// requesters, with a single registered, id-tagged result channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_id,
  output logic             busy
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             ptr;
  logic             can_issue;
  logic             grant0;
  logic             grant1;
  logic             handshake;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_op;
  logic [WIDTH:0]   sum;

  // Reset blocks issue so no handshake is reported on a reset edge.
  assign can_issue = ~rst & ((state == EMPTY) | res_ready);

  assign grant0 = req0_valid & (~ptr | ~req1_valid);
  assign grant1 = req1_valid & ( ptr | ~req0_valid);

  assign req0_ready = can_issue & grant0;
  assign req1_ready = can_issue & grant1;
  assign handshake  = req0_ready | req1_ready;

  assign sel_a  = req1_ready ? req1_a  : req0_a;
  assign sel_b  = req1_ready ? req1_b  : req0_b;
  assign sel_op = req1_ready ? req1_op : req0_op;

  // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
  assign sum = {1'b0, sel_a}
             + {1'b0, (sel_op ? ~sel_b : sel_b)}
             + {{WIDTH{1'b0}}, sel_op};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ptr       <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
    end else if (handshake) begin
      state     <= FULL;
      ptr       <= req0_ready;
      res_data  <= sum[WIDTH-1:0];
      res_carry <= sum[WIDTH];
      res_id    <= req1_ready;
    end else if (state == FULL && res_ready) begin
      state     <= EMPTY;
    end
  end

  assign res_valid = (state == FULL);
  assign busy      = res_valid;

endmodule

`default_nettype wire

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit add/subtract unit between two requesters. Each requester presents operands and an op select over a valid/ready handshake. The arbiter grants one request per issue, registers the result, and returns it on a single valid/ready result channel tagged with the winning requester's id. It sits between the pin-level input capture and the output driver, so the arithmetic datapath is owned by exactly one client at a time.

## Interface
- WIDTH, 8, operand and result width in bits (WIDTH >= 2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 handshake accept
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  1  requester 0 op: 0 = a+b, 1 = a-b
- req1_valid, req1_ready, req1_a, req1_b, req1_op  (same as requester 0, for requester 1)
- res_valid  out  1  result register holds an unconsumed result
- res_ready  in  1  consumer accepts the result
- res_data  out  WIDTH  result, low WIDTH bits
- res_carry  out  1  add: carry-out; sub: 1 when a >= b unsigned (no borrow)
- res_id  out  1  requester that produced res_data
- busy  out  1  equals res_valid (state FULL)

## Operation
- States: EMPTY (no held result) and FULL (result held).
- Issue condition: `can_issue = (state == EMPTY) | (state == FULL & res_ready)`.
- Priority pointer `ptr` (1 bit) selects the preferred requester.
  - Grant goes to the preferred requester if it is valid, otherwise to the other requester if valid.
  - `reqN_ready = can_issue & grantN`. This is combinational from valid, ptr, state and res_ready.
  - At most one ready is high in any cycle.
  - A requester's ready is never asserted while its valid is low.
- A handshake occurs on `reqN_valid & reqN_ready`. On that edge:
  - The granted operands are computed as one (WIDTH+1)-bit operation:
    - add: `{carry, data} = a + b`
    - sub: `{carry, data} = a + ~b + 1`
  - The result is loaded into res_data, res_carry and res_id.
  - State becomes FULL.
  - ptr is set to the non-granted requester.
- In FULL with res_ready high and no handshake, state becomes EMPTY.
- In FULL with res_ready high and a handshake, state stays FULL and the new result replaces the old one. This is back-to-back, one result per cycle.
- In FULL with res_ready low: res_data, res_carry and res_id are held stable, both readies are 0, and ptr is unchanged.
- ptr changes only on a handshake, not on mere valid activity.
- Requester contract: valid, operands and op stay stable until ready. The arbiter samples them only on the handshake cycle. Dropping valid before ready is allowed and cancels that request without side effects.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

## Timing
- Reset values: state EMPTY, ptr = 0 (requester 0 preferred), res_valid = 0, res_data = 0, res_carry = 0, res_id = 0, busy = 0. Readies follow from state and are high on the first cycle after reset if valid is asserted.
- Latency: a handshake at edge N makes res_valid high from edge N onward, i.e. visible in the cycle after the request was accepted.
- Throughput: 1 result per cycle while res_ready stays high.
- Simultaneous valid on both requesters: the grant follows ptr, and the loser is granted at the next issue opportunity. Worst-case wait is 1 grant.
- Reset asserted in FULL: the pending result is discarded, all outputs return to their reset values on that edge, and no handshake is reported that cycle.
- Reset overrides the handshake: readies are 0 while rst is high.

## Test plan
- Reset: hold rst for 2 cycles with both valids high. Then res_valid = 0, res_data = 0x00, res_id = 0, both readies 0.
- Single add: req0 a=0x7F, b=0x01, op=0, res_ready=1. Then req0_ready is high the same cycle, and the next cycle shows res_valid=1, data=0x80, carry=0, id=0.
- Contention and round-robin: both valid from reset, with req0 = 0x10+0x20 and req1 = 0xFF+0x02, both held. Results in consecutive cycles are:
  - data 0x30, carry 0, id 0
  - then data 0x01, carry 1, id 1
- Backpressure: after a result, hold res_ready=0 for 3 cycles with req1 valid. Then res_data and res_id are stable, and both readies are 0. Raising res_ready causes req1 to be accepted that same cycle, and the new result appears on the next edge.
- Subtract: req1 a=0x05, b=0x07, op=1 gives data 0xFE, carry 0. Then a=0x07, b=0x05 gives data 0x02, carry 1.
- Reset mid-result: with res_valid=1 and res_ready=0, assert rst for 1 cycle. Then res_valid=0, res_data=0, and ptr=0: a following simultaneous request is granted to req0 first.
